// File: rtl/packet_filter_pkg.sv
// Shared types for the frame egress read stage: FSM state encoding and the
// frame descriptor handed over by the switch FSM.
package packet_filter_pkg;

    localparam int unsigned AddrWidth = 11;
    localparam int unsigned LenWidth  = 11;

    typedef enum logic [1:0] {
        StIdle,
        StSeek,
        StStream,
        StDrain
    } egress_state_e;

    typedef struct packed {
        logic [AddrWidth:0]  start_ptr;
        logic [LenWidth-1:0] len;
        logic                drop;
    } frame_desc_t;

endpackage

// File: rtl/frame_egress_if.sv
// Descriptor, frame FIFO read and egress stream signals of the egress stage.
// The master modport is the egress stage itself.
interface frame_egress_if #(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned LEN_WIDTH  = 11
) ();

    logic                  desc_valid;
    logic                  desc_ready;
    logic [ADDR_WIDTH:0]   desc_start_ptr;
    logic [LEN_WIDTH-1:0]  desc_len;
    logic                  desc_drop;

    logic                  frame_ren;
    logic                  frame_rrst;
    logic [ADDR_WIDTH:0]   frame_rst_rptr;
    logic [19:0]           frame_rdata;

    logic                  egress_tvalid;
    logic                  egress_tready;
    logic [15:0]           egress_tdata;
    logic                  egress_tlast;

    logic                  frame_done;

    modport master (
        input  desc_valid, desc_start_ptr, desc_len, desc_drop, frame_rdata, egress_tready,
        output desc_ready, frame_ren, frame_rrst, frame_rst_rptr, egress_tvalid, egress_tdata,
               egress_tlast, frame_done
    );

    modport slave (
        output desc_valid, desc_start_ptr, desc_len, desc_drop, frame_rdata, egress_tready,
        input  desc_ready, frame_ren, frame_rrst, frame_rst_rptr, egress_tvalid, egress_tdata,
               egress_tlast, frame_done
    );

endinterface

// File: rtl/egress_skid_buf.sv
// Two-entry FIFO of {tdata, tlast} sitting between the frame FIFO read port and
// the egress stream; the caller guarantees it never pushes when full.
module egress_skid_buf (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        push_i,
    input  logic [15:0] push_data_i,
    input  logic        push_last_i,
    input  logic        pop_i,
    output logic        valid_o,
    output logic [15:0] data_o,
    output logic        last_o,
    output logic [1:0]  occ_o
);

    logic [16:0] mem_q [2];
    logic        wr_q, wr_d;
    logic        rd_q, rd_d;
    logic [1:0]  cnt_q, cnt_d;

    always_comb begin
        wr_d  = push_i ? ~wr_q : wr_q;
        rd_d  = pop_i ? ~rd_q : rd_q;
        cnt_d = cnt_q + {1'b0, push_i} - {1'b0, pop_i};
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= {push_last_i, push_data_i};
            end
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign valid_o = (cnt_q != 2'd0);
    assign data_o  = mem_q[rd_q][15:0];
    assign last_o  = mem_q[rd_q][16];
    assign occ_o   = cnt_q;

endmodule

// File: rtl/frame_egress.sv
// Frame FIFO read stage: accepts one descriptor, then streams the frame to the
// egress port with tlast, or skips it by reloading the FIFO read pointer.
module frame_egress
    import packet_filter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned LEN_WIDTH  = 11
) (
    input  logic          clk_i,
    input  logic          reset_i,
    frame_egress_if.master bus
);

    localparam int unsigned PtrW = ADDR_WIDTH + 1;

    egress_state_e        state_q, state_d;
    logic [PtrW-1:0]      start_q, start_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic                 drop_q, drop_d;
    logic [LEN_WIDTH-1:0] rem_q, rem_d;
    logic                 inflight_q, inflight_d;
    logic                 infl_last_q, infl_last_d;
    logic                 done_q, done_d;

    logic                 pop;
    logic [1:0]           occ;
    logic [2:0]           fill;
    logic                 buf_valid;
    logic [15:0]          buf_data;
    logic                 buf_last;
    logic                 unused_rdata_hi;

    assign unused_rdata_hi = ^bus.frame_rdata[19:16];

    assign pop  = buf_valid & bus.egress_tready;
    // Words held after this cycle if no new read is issued.
    assign fill = {1'b0, occ} + {2'b0, inflight_q} - {2'b0, pop};

    always_comb begin
        state_d            = state_q;
        start_d            = start_q;
        len_d              = len_q;
        drop_d             = drop_q;
        rem_d              = rem_q;
        done_d             = 1'b0;
        bus.desc_ready     = 1'b0;
        bus.frame_ren      = 1'b0;
        bus.frame_rrst     = 1'b0;
        bus.frame_rst_rptr = '0;
        bus.frame_done     = done_q;

        unique case (state_q)
            StIdle: begin
                bus.desc_ready = ~done_q & ~reset_i;
                if (bus.desc_valid && bus.desc_ready) begin
                    start_d = bus.desc_start_ptr;
                    len_d   = bus.desc_len;
                    drop_d  = bus.desc_drop;
                    state_d = StSeek;
                end
            end
            StSeek: begin
                bus.frame_rrst = 1'b1;
                if (drop_q || (len_q == '0)) begin
                    bus.frame_rst_rptr = start_q + PtrW'(len_q);
                    done_d             = 1'b1;
                    state_d            = StIdle;
                end else begin
                    bus.frame_rst_rptr = start_q;
                    rem_d              = len_q;
                    state_d            = StStream;
                end
            end
            StStream: begin
                if ((rem_q != '0) && (fill < 3'd2)) begin
                    bus.frame_ren = 1'b1;
                    rem_d         = rem_q - LEN_WIDTH'(1);
                    if (rem_q == LEN_WIDTH'(1)) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (pop && buf_last) begin
                    bus.frame_done = 1'b1;
                    state_d        = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        inflight_d  = bus.frame_ren;
        infl_last_d = bus.frame_ren && (rem_q == LEN_WIDTH'(1));
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            start_q     <= '0;
            len_q       <= '0;
            drop_q      <= 1'b0;
            rem_q       <= '0;
            inflight_q  <= 1'b0;
            infl_last_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            len_q       <= len_d;
            drop_q      <= drop_d;
            rem_q       <= rem_d;
            inflight_q  <= inflight_d;
            infl_last_q <= infl_last_d;
            done_q      <= done_d;
        end
    end

    egress_skid_buf u_skid_buf (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .push_i      (inflight_q),
        .push_data_i (bus.frame_rdata[15:0]),
        .push_last_i (infl_last_q),
        .pop_i       (pop),
        .valid_o     (buf_valid),
        .data_o      (buf_data),
        .last_o      (buf_last),
        .occ_o       (occ)
    );

    assign bus.egress_tvalid = buf_valid;
    assign bus.egress_tdata  = buf_data;
    assign bus.egress_tlast  = buf_last;

endmodule

// File: tb/tb_frame_egress.sv
// Directed bench for frame_egress: a frame FIFO model feeds the DUT, stimulus
// pushes hand-computed words into a scoreboard that a negedge monitor drains.
module tb_frame_egress;
    import packet_filter_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    frame_egress_if #(.ADDR_WIDTH(11), .LEN_WIDTH(11)) bus ();

    frame_egress #(.ADDR_WIDTH(11), .LEN_WIDTH(11)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Frame FIFO model: one-cycle read latency, pointer reload on rrst.
    logic [19:0] mem [4096];
    logic [11:0] rptr = '0;
    initial bus.frame_rdata = '0;
    always @(posedge clk) begin
        if (bus.frame_rrst) begin
            rptr <= bus.frame_rst_rptr;
        end else if (bus.frame_ren) begin
            bus.frame_rdata <= mem[rptr];
            rptr <= rptr + 12'd1;
        end
    end

    logic [16:0] exp_q [$];
    int first_tv, tv_count, rrst_count, done_count, done_cyc, pops, outs;
    logic [11:0] last_rptr;
    logic bp_mode = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Egress sink: pattern 1,0,0,1 under back-pressure, otherwise always ready.
    initial begin
        logic [3:0] pat;
        int k;
        pat = 4'b1001;
        k = 0;
        bus.egress_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) begin
                bus.egress_tready = pat[3 - (k % 4)];
                k++;
            end else begin
                bus.egress_tready = 1'b1;
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        logic        hold_v;
        logic [16:0] hold_word;
        logic        pop;
        hold_v = 1'b0;
        hold_word = '0;
        done_count = 0;
        pops = 0;
        outs = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                outs = 0;
                hold_v = 1'b0;
            end else begin
                pop = bus.egress_tvalid & bus.egress_tready;
                if (bus.egress_tvalid) begin
                    tv_count++;
                    if (first_tv < 0) first_tv = cyc;
                end
                if (hold_v) begin
                    chk("egress_stable", {15'd0, bus.egress_tvalid, bus.egress_tlast,
                        bus.egress_tdata}, {15'd0, 1'b1, hold_word});
                end
                hold_v = bus.egress_tvalid & ~bus.egress_tready;
                hold_word = {bus.egress_tlast, bus.egress_tdata};
                if (pop) begin
                    pops++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL egress_extra: got word 0x%0h expected none",
                                 {bus.egress_tlast, bus.egress_tdata});
                    end else begin
                        chk("egress_word", {15'd0, bus.egress_tlast, bus.egress_tdata},
                            {15'd0, exp_q.pop_front()});
                    end
                end
                if (bus.frame_ren || bus.frame_rrst) begin
                    chk("ren_rrst_excl", {31'd0, bus.frame_ren & bus.frame_rrst}, 32'd0);
                end
                outs = outs + (bus.frame_ren ? 1 : 0) - (pop ? 1 : 0);
                if (bus.frame_ren) chk("outstanding_over2", {31'd0, outs > 2}, 32'd0);
                if (bus.frame_done) begin
                    done_count++;
                    done_cyc = cyc;
                end
                if (bus.frame_rrst) begin
                    rrst_count++;
                    last_rptr = bus.frame_rst_rptr;
                end
            end
        end
    end

    task automatic send(input frame_desc_t d, output int t);
        int n;
        first_tv = -1;
        tv_count = 0;
        rrst_count = 0;
        @(posedge clk);
        #1;
        bus.desc_valid = 1'b1;
        bus.desc_start_ptr = d.start_ptr;
        bus.desc_len = d.len;
        bus.desc_drop = d.drop;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.desc_ready && n < 50);
        chk("desc_accept_timeout", {31'd0, bus.desc_ready}, 32'd1);
        t = cyc;
        @(posedge clk);
        #1;
        bus.desc_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        int base;
        n = 0;
        base = done_count;
        while (done_count == base && n < budget) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk("frame_done_timeout", {31'd0, done_count != base}, 32'd1);
        chk("ready_low_at_done", {31'd0, bus.desc_ready}, 32'd0);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ren"}, {31'd0, bus.frame_ren}, 32'd0);
        chk({tag, "_rrst"}, {31'd0, bus.frame_rrst}, 32'd0);
        chk({tag, "_rst_rptr"}, {20'd0, bus.frame_rst_rptr}, 32'd0);
        chk({tag, "_tvalid"}, {31'd0, bus.egress_tvalid}, 32'd0);
        chk({tag, "_tlast"}, {31'd0, bus.egress_tlast}, 32'd0);
        chk({tag, "_tdata"}, {16'd0, bus.egress_tdata}, 32'd0);
        chk({tag, "_done"}, {31'd0, bus.frame_done}, 32'd0);
        chk({tag, "_desc_ready"}, {31'd0, bus.desc_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        int n;
        int p0;
        for (int i = 0; i < 4096; i++) mem[i] = {4'h7, 4'h0, i[11:0]};
        mem[12'h010] = 20'hE00A1;
        mem[12'h011] = 20'hE00A2;
        mem[12'h012] = 20'hE00A3;
        mem[12'hFFE] = 20'h5B001;
        mem[12'hFFF] = 20'h5B002;
        mem[12'h000] = 20'h5B003;
        mem[12'h001] = 20'h5B004;
        for (int i = 0; i < 5; i++) mem[12'h200 + i] = 20'h900C1 + i;
        mem[12'h300] = 20'h300D1;
        mem[12'h301] = 20'h300D2;

        bus.desc_valid = 1'b0;
        bus.desc_start_ptr = '0;
        bus.desc_len = '0;
        bus.desc_drop = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset_desc_ready", {31'd0, bus.desc_ready}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk_idle_outputs("post_reset");

        // Three-word frame, sink always ready.
        exp_q.push_back(17'h000A1);
        exp_q.push_back(17'h000A2);
        exp_q.push_back(17'h100A3);
        send('{start_ptr: 12'h010, len: 11'd3, drop: 1'b0}, t);
        wait_done(40);
        chk("s3_first_tvalid", first_tv, t + 4);
        chk("s3_done_cycle", done_cyc, t + 6);
        chk("s3_rrst_count", rrst_count, 1);
        chk("s3_rst_rptr", {20'd0, last_rptr}, 32'h010);
        chk("s3_queue_empty", exp_q.size(), 0);

        // Same frame under back-pressure.
        bp_mode = 1'b1;
        exp_q.push_back(17'h000A1);
        exp_q.push_back(17'h000A2);
        exp_q.push_back(17'h100A3);
        send('{start_ptr: 12'h010, len: 11'd3, drop: 1'b0}, t);
        wait_done(80);
        chk("bp_queue_empty", exp_q.size(), 0);
        bp_mode = 1'b0;

        // Dropped frame.
        send('{start_ptr: 12'h100, len: 11'd759, drop: 1'b1}, t);
        wait_done(20);
        repeat (3) @(negedge clk);
        chk("drop_done_cycle", done_cyc, t + 2);
        chk("drop_rrst_count", rrst_count, 1);
        chk("drop_rst_rptr", {20'd0, last_rptr}, 32'h3F7);
        chk("drop_no_tvalid", tv_count, 0);

        // Stream across pointer wrap.
        exp_q.push_back(17'h0B001);
        exp_q.push_back(17'h0B002);
        exp_q.push_back(17'h0B003);
        exp_q.push_back(17'h1B004);
        send('{start_ptr: 12'hFFE, len: 11'd4, drop: 1'b0}, t);
        wait_done(40);
        chk("wrap_done_cycle", done_cyc, t + 7);
        chk("wrap_rst_rptr", {20'd0, last_rptr}, 32'hFFE);
        chk("wrap_queue_empty", exp_q.size(), 0);

        // Drop across pointer wrap.
        send('{start_ptr: 12'hFFE, len: 11'd4, drop: 1'b1}, t);
        wait_done(20);
        chk("wrapdrop_rst_rptr", {20'd0, last_rptr}, 32'h002);
        chk("wrapdrop_done_cycle", done_cyc, t + 2);

        // Zero-length frame behaves as a drop.
        send('{start_ptr: 12'h050, len: 11'd0, drop: 1'b0}, t);
        wait_done(20);
        repeat (3) @(negedge clk);
        chk("len0_rst_rptr", {20'd0, last_rptr}, 32'h050);
        chk("len0_done_cycle", done_cyc, t + 2);
        chk("len0_no_tvalid", tv_count, 0);

        // Reset after two of five words.
        for (int i = 0; i < 5; i++) exp_q.push_back(17'h000C1 + 17'(i) + (i == 4 ? 17'h10000 : 0));
        p0 = pops;
        send('{start_ptr: 12'h200, len: 11'd5, drop: 1'b0}, t);
        n = 0;
        while (pops < p0 + 2 && n < 40) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk("mid_reset_two_sent", pops - p0, 2);
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk_idle_outputs("mid_reset");

        exp_q.push_back(17'h000D1);
        exp_q.push_back(17'h100D2);
        send('{start_ptr: 12'h300, len: 11'd2, drop: 1'b0}, t);
        wait_done(40);
        chk("after_reset_first_tvalid", first_tv, t + 4);
        chk("after_reset_done_cycle", done_cyc, t + 5);
        chk("after_reset_queue_empty", exp_q.size(), 0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
